usrt_rec: RTL and testbench

// - Synchronous serial (USRT) byte receiver for the calculator input path.
// - Samples usrt_rx on rising edges of the external usrt_clk, all logic in the clk domain.
// - Decodes start/data/stop frames and presents each good byte on USRT_data with a one-cycle rdy strobe.

---
 rtl/usrt_rec.sv | 146 ++++++++++++++
 tb/tb_usrt_rec.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/usrt_rec.sv
// rtl/usrt_rec.sv - USRT byte receiver: synced usrt_clk/usrt_rx, start/data/stop decode, rdy strobe.
// Optional even parity bit after the data bits when USRT_REC_PARITY_EN is defined.
module usrt_rec #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 usrt_rx,
    input  logic                 usrt_clk,
    output logic [DATA_BITS-1:0] USRT_data,
    output logic                 rdy
);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] rx_sync_q;
    logic                   clk_prev_q;
    logic                   sample;
    logic                   rx_bit;
    logic                   frame_ok;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   rdy_q, rdy_d;

    // Both chains have the same depth so an rx edge aligned with the usrt_clk rise is seen as new data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_q <= '0;
            rx_sync_q  <= '1;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], usrt_clk};
            rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], usrt_rx};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sample = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign rx_bit = rx_sync_q[SYNC_STAGES-1];

`ifdef USRT_REC_PARITY_EN
    logic perr_q, perr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    always_comb begin
        perr_d = perr_q;
        if (sample) begin
            if (state_q == IDLE && !rx_bit) begin
                perr_d = 1'b0;
            end else if (state_q == PARITY) begin
                perr_d = (^shift_q) ^ rx_bit;
            end
        end
    end

    assign frame_ok = ~perr_q;
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sample && !rx_bit) state_d = DATA;
            end
            DATA: begin
                if (sample && cnt_q == LAST_BIT) begin
`ifdef USRT_REC_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef USRT_REC_PARITY_EN
            PARITY: begin
                if (sample) state_d = STOP;
            end
`endif
            STOP: begin
                if (sample) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = 1'b0;
        if (sample) begin
            case (state_q)
                IDLE: begin
                    if (!rx_bit) cnt_d = '0;
                end
                DATA: begin
                    // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                    shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                end
                STOP: begin
                    if (rx_bit && frame_ok) begin
                        data_d = shift_q;
                        rdy_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign USRT_data = data_q;
    assign rdy       = rdy_q;
endmodule

// File: tb/tb_usrt_rec.sv
// tb/tb_usrt_rec.sv - directed self-checking bench for usrt_rec.
module tb_usrt_rec;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       usrt_rx = 1'b1;
    logic       usrt_clk = 1'b0;
    logic [7:0] USRT_data;
    logic       rdy;

    int         n_comp = 0;
    int         n_fail = 0;
    int         rdy_cnt = 0;
    int         wide_cnt = 0;
    logic       rdy_prev = 1'b0;
    logic [7:0] cap[$];

    usrt_rec #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .usrt_rx  (usrt_rx),
        .usrt_clk (usrt_clk),
        .USRT_data(USRT_data),
        .rdy      (rdy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy) begin
            rdy_cnt++;
            cap.push_back(USRT_data);
            if (rdy_prev) wide_cnt++;
        end
        rdy_prev = rdy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_comp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rx changes on the usrt_clk falling edge, held for the whole 80 ns bit.
    task automatic send_bit(input logic b);
        usrt_clk = 1'b0;
        usrt_rx  = b;
        #40;
        usrt_clk = 1'b1;
        #40;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef USRT_REC_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    int base;

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_data", {24'd0, USRT_data}, 32'h00);
        @(negedge clk);
        rst = 1'b1;
        idle_bits(2);

        // rx in phase with usrt_clk: every sample lands on rx=1.
        for (int i = 0; i < 12; i++) begin
            usrt_clk = 1'b0;
            usrt_rx  = 1'b0;
            #40;
            usrt_clk = 1'b1;
            usrt_rx  = 1'b1;
            #40;
        end
        idle_bits(2);
        check("phase_rdy_cnt", rdy_cnt, 0);
        check("phase_data", {24'd0, USRT_data}, 32'h00);

        // Bit sequence 0,1,0,1,0,0,1,0,1,1 on the line.
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        check("a5_rdy_cnt", rdy_cnt, 1);
        check("a5_data", {24'd0, USRT_data}, 32'hA5);
        check("a5_cap", (cap.size() >= 1) ? {24'd0, cap[0]} : 32'hFFFF, 32'hA5);

        base = rdy_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_bits(1);
        check("b2b_rdy_cnt", rdy_cnt - base, 2);
        check("b2b_first", (cap.size() >= 2) ? {24'd0, cap[1]} : 32'hFFFF, 32'h3C);
        check("b2b_second", (cap.size() >= 3) ? {24'd0, cap[2]} : 32'hFFFF, 32'hFF);
        check("b2b_data", {24'd0, USRT_data}, 32'hFF);

        base = rdy_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        idle_bits(1);
        check("framing_err_rdy", rdy_cnt - base, 0);
        check("framing_err_data", {24'd0, USRT_data}, 32'hFF);
        send_frame(8'h01, 1'b1, 1'b1);
        idle_bits(1);
        check("after_err_rdy", rdy_cnt - base, 1);
        check("after_err_data", {24'd0, USRT_data}, 32'h01);

        // Abort after start + 4 data bits of 8'h96.
        base = rdy_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        usrt_clk = 1'b0;
        usrt_rx  = 1'b1;
        #40;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_data", {24'd0, USRT_data}, 32'h00);
        idle_bits(3);
        check("abort_rdy", rdy_cnt - base, 0);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle_bits(1);
        check("c3_rdy_cnt", rdy_cnt - base, 1);
        check("c3_data", {24'd0, USRT_data}, 32'hC3);

`ifdef USRT_REC_PARITY_EN
        base = rdy_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(1);
        check("par_ok_rdy", rdy_cnt - base, 1);
        check("par_ok_data", {24'd0, USRT_data}, 32'hA5);
        send_frame(8'h5A, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_bits(1);
        check("par_bad_rdy", rdy_cnt - base, 1);
        check("par_bad_data", {24'd0, USRT_data}, 32'hA5);
`endif

        check("rdy_one_cycle", wide_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
        $finish;
    end
endmodule
